// File: rtl/count_mod_n.sv
// Parametrised up/down modulo-N counter with load, clear, wrap/saturate, terminal count and sticky overflow.
// Optional compare output enabled with `define COUNT_MOD_N_CMP_EN.
module count_mod_n #(
    parameter int     WIDTH    = 8,
    parameter longint MODULUS  = 256,
    parameter bit     SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             up,
`ifdef COUNT_MOD_N_CMP_EN
    input  logic [WIDTH-1:0] cmp_val,
    output logic             cmp_hit,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    localparam longint           MOD_LIM = longint'(1) << WIDTH;
    localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "count_mod_n: WIDTH out of range 2..32");
    end
    if (MODULUS < 2 || MODULUS > MOD_LIM) begin : g_bad_modulus
        $fatal(1, "count_mod_n: MODULUS out of range 2..2^WIDTH");
    end

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] out_nxt;
    logic             ovf_nxt;

    assign at_max  = (out == MAX);
    assign at_zero = (out == '0);
    assign tc      = en & ~clr & ~load & ((up & at_max) | (~up & at_zero));

    always_comb begin
        out_nxt = out;
        ovf_nxt = ovf;
        if (clr) begin
            out_nxt = '0;
            ovf_nxt = 1'b0;
        end else if (load) begin
            out_nxt = (data > MAX) ? MAX : data;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    ovf_nxt = 1'b1;
                    out_nxt = SATURATE ? out : '0;
                end else begin
                    out_nxt = out + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    ovf_nxt = 1'b1;
                    out_nxt = SATURATE ? out : MAX;
                end else begin
                    out_nxt = out - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
            ovf <= 1'b0;
        end else begin
            out <= out_nxt;
            ovf <= ovf_nxt;
        end
    end

`ifdef COUNT_MOD_N_CMP_EN
    // landed marks that out was written by a count or load on the previous edge,
    // so a hit fires one cycle after the match appears, never from clr/rst alone.
    logic landed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            landed  <= 1'b0;
            cmp_hit <= 1'b0;
        end else begin
            landed  <= ~clr & (load | en);
            cmp_hit <= landed & (out == cmp_val);
        end
    end
`endif

endmodule

// File: tb/tb_count_mod_n.sv
// Directed self-checking bench for count_mod_n: a wrap instance and a saturate instance
// (both WIDTH=8, MODULUS=10) driven by shared controls.
module tb_count_mod_n;

    logic       clk = 1'b0;
    logic       rst, clr, load, en, up;
    logic [7:0] data;
    logic [7:0] w_out, s_out;
    logic       w_tc, s_tc, w_ovf, s_ovf;
`ifdef COUNT_MOD_N_CMP_EN
    logic [7:0] cmp_val;
    logic       w_hit, s_hit;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    count_mod_n #(.WIDTH(8), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .data(data), .en(en), .up(up),
`ifdef COUNT_MOD_N_CMP_EN
        .cmp_val(cmp_val), .cmp_hit(w_hit),
`endif
        .out(w_out), .tc(w_tc), .ovf(w_ovf)
    );

    count_mod_n #(.WIDTH(8), .MODULUS(10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .data(data), .en(en), .up(up),
`ifdef COUNT_MOD_N_CMP_EN
        .cmp_val(cmp_val), .cmp_hit(s_hit),
`endif
        .out(s_out), .tc(s_tc), .ovf(s_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_up_out[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_up_tc[12]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int exp_up_ovf[12]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    int exp_dn_out[11]  = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8};
    int exp_dn_tc[11]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int exp_sat_out[5]  = '{8, 9, 9, 9, 9};
    int exp_sat_tc[5]   = '{0, 0, 1, 1, 1};
    int exp_sat_ovf[5]  = '{0, 0, 1, 1, 1};
`ifdef COUNT_MOD_N_CMP_EN
    int exp_hit[6]      = '{0, 0, 0, 0, 1, 0};
`endif

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; data = 8'd0;
`ifdef COUNT_MOD_N_CMP_EN
        cmp_val = 8'd4;
`endif
        #1;
        chk("reset_out", 32'(w_out), 32'd0);
        chk("reset_ovf", 32'(w_ovf), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // load 5 then asynchronous reset between edges
        load = 1'b1; data = 8'd5;
        tick();
        load = 1'b0;
        chk("load5_out", 32'(w_out), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out", 32'(w_out), 32'd0);
        chk("async_rst_ovf", 32'(w_ovf), 32'd0);
        rst = 1'b0;
        tick();

        // count up 12 clocks from 0 in wrap mode
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk($sformatf("up_tc_%0d", i), 32'(w_tc), 32'(exp_up_tc[i]));
            tick();
            chk($sformatf("up_out_%0d", i), 32'(w_out), 32'(exp_up_out[i]));
            chk($sformatf("up_ovf_%0d", i), 32'(w_ovf), 32'(exp_up_ovf[i]));
        end
        en = 1'b0;

        // load clamps, ovf survives load
        load = 1'b1; data = 8'd10;
        tick();
        chk("clamp10_out", 32'(w_out), 32'd9);
        data = 8'd200;
        tick();
        chk("clamp200_out", 32'(w_out), 32'd9);
        chk("load_keeps_ovf", 32'(w_ovf), 32'd1);
        load = 1'b0;

        // count down 11 clocks from 9
        en = 1'b1; up = 1'b0;
        for (int i = 0; i < 11; i++) begin
            #1;
            chk($sformatf("dn_tc_%0d", i), 32'(w_tc), 32'(exp_dn_tc[i]));
            tick();
            chk($sformatf("dn_out_%0d", i), 32'(w_out), 32'(exp_dn_out[i]));
        end
        en = 1'b0;

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_out", 32'(w_out), 32'd0);
        chk("clr_ovf", 32'(w_ovf), 32'd0);

        // saturate: up from 7 for 5 clocks
        load = 1'b1; data = 8'd7;
        tick();
        load = 1'b0;
        chk("sat_load7", 32'(s_out), 32'd7);
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("sat_tc_%0d", i), 32'(s_tc), 32'(exp_sat_tc[i]));
            tick();
            chk($sformatf("sat_out_%0d", i), 32'(s_out), 32'(exp_sat_out[i]));
            chk($sformatf("sat_ovf_%0d", i), 32'(s_ovf), 32'(exp_sat_ovf[i]));
        end
        en = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("sat_clr_out", 32'(s_out), 32'd0);
        chk("sat_clr_ovf", 32'(s_ovf), 32'd0);

        // saturate at zero going down
        en = 1'b1; up = 1'b0;
        tick();
        chk("sat_dn_hold", 32'(s_out), 32'd0);
        chk("sat_dn_ovf", 32'(s_ovf), 32'd1);

        // clr beats load and en; tc masked by clr
        clr = 1'b1; load = 1'b1; data = 8'd3;
        #1;
        chk("tc_masked_clr", 32'(s_tc), 32'd0);
        tick();
        chk("clr_wins_out", 32'(s_out), 32'd0);
        chk("clr_wins_ovf", 32'(s_ovf), 32'd0);
        clr = 1'b0;
        #1;
        chk("tc_masked_load", 32'(s_tc), 32'd0);
        tick();
        chk("load_wins_out", 32'(s_out), 32'd3);
        load = 1'b0;

        // direction change takes effect on the very next edge
        up = 1'b1;
        tick();
        chk("dir_up_out", 32'(s_out), 32'd4);
        up = 1'b0;
        tick();
        chk("dir_dn_out", 32'(s_out), 32'd3);
        en = 1'b0;

`ifdef COUNT_MOD_N_CMP_EN
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        chk("cmp_after_clr", 32'(w_hit), 32'd0);
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("cmp_hit_%0d", i), 32'(w_hit), 32'(exp_hit[i]));
        end
        en = 1'b0;
        load = 1'b1; data = 8'd4;
        tick();
        load = 1'b0;
        chk("cmp_load_out", 32'(w_out), 32'd4);
        chk("cmp_load_hit0", 32'(w_hit), 32'd0);
        tick();
        chk("cmp_load_hit1", 32'(w_hit), 32'd1);
        tick();
        chk("cmp_load_hit2", 32'(w_hit), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
